// File: rtl/cp0_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cp0_irq_ctrl
// Brief    : Latches, masks and prioritises device interrupts and offers one
//            source at a time to CP0 Cause.IP, tracking it until eret.
//            Optional service counter enabled by defining CP0_IRQ_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module cp0_irq_ctrl #(
    parameter int                 NUM_SRC  = 6,
    parameter logic [NUM_SRC-1:0] EDGE_SRC = 6'b000001,
    parameter logic [NUM_SRC-1:0] MASK_RST = {NUM_SRC{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [NUM_SRC-1:0] cfg_wdata,
    output logic [NUM_SRC-1:0] cfg_rdata,
    input  logic               cp0_take,
    input  logic               cp0_eret,
    output logic [NUM_SRC-1:0] hwint,
    output logic [2:0]         irq_id,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] hwint_q, hwint_d;
    logic [2:0]         irq_id_q, irq_id_d;
    logic               busy_q, busy_d;

    logic [NUM_SRC-1:0] w_pending;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_sel_onehot;
    logic [2:0]         w_sel;
    logic               w_take_fire;
    logic [NUM_SRC-1:0] w_count_rd;

    // Edge sources keep a sticky flop; level sources simply follow the
    // registered line, so their flop bits are forced to zero.
    assign w_set     = irq_in & ~irq_q & EDGE_SRC;
    assign w_clr     = ((cfg_we && cfg_addr == 2'd1) ? cfg_wdata : '0)
                     | (w_take_fire ? hwint_q : '0);
    assign pending_d = (w_set | (pending_q & ~w_clr)) & EDGE_SRC;
    assign w_pending = pending_q | (irq_q & ~EDGE_SRC);
    assign w_eligible = w_pending & mask_q;

    assign mask_d = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : mask_q;

    always_comb begin
        w_sel = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_sel = 3'(i);
            end
        end
        w_sel_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_sel_onehot[i] = (w_sel == 3'(i));
        end
    end

    // In REQ, hwint_q is the one-hot of irq_id_q, so it doubles as the
    // selector for withdrawal checks and take-time pending clears.
    always_comb begin
        state_d     = state_q;
        hwint_d     = hwint_q;
        irq_id_d    = irq_id_q;
        busy_d      = busy_q;
        w_take_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hwint_d = '0;
                busy_d  = 1'b0;
                if (|w_eligible) begin
                    state_d  = ST_REQ;
                    irq_id_d = w_sel;
                    hwint_d  = w_sel_onehot;
                end
            end
            ST_REQ: begin
                if (cp0_take) begin
                    state_d     = ST_SERVICE;
                    hwint_d     = '0;
                    busy_d      = 1'b1;
                    w_take_fire = 1'b1;
                end else if (!(|(w_eligible & hwint_q))) begin
                    state_d = ST_IDLE;
                    hwint_d = '0;
                end
            end
            ST_SERVICE: begin
                hwint_d = '0;
                busy_d  = 1'b1;
                if (cp0_eret) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hwint_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RST;
            hwint_q   <= '0;
            irq_id_q  <= 3'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_in;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            hwint_q   <= hwint_d;
            irq_id_q  <= irq_id_d;
            busy_q    <= busy_d;
        end
    end

`ifdef CP0_IRQ_CNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (cfg_we && cfg_addr == 2'd2) begin
            count_d = '0;
        end else if (w_take_fire) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign w_count_rd = count_q[NUM_SRC-1:0];
`else
    assign w_count_rd = '0;
`endif

    always_comb begin
        case (cfg_addr)
            2'd0:    cfg_rdata = mask_q;
            2'd1:    cfg_rdata = w_pending;
            2'd2:    cfg_rdata = w_count_rd;
            default: cfg_rdata = '0;
        endcase
    end

    assign hwint  = hwint_q;
    assign irq_id = irq_id_q;
    assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cp0_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_irq_ctrl
// Brief    : Directed stimulus with a cycle-stamped expectation queue that an
//            independent monitor drains and compares on the falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_cp0_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] irq_in;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [5:0] cfg_wdata;
    logic [5:0] cfg_rdata;
    logic       cp0_take;
    logic       cp0_eret;
    logic [5:0] hwint;
    logic [2:0] irq_id;
    logic       busy;

    cp0_irq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .cp0_take  (cp0_take),
        .cp0_eret  (cp0_eret),
        .hwint     (hwint),
        .irq_id    (irq_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         rd;
        logic [5:0] hw;
        logic       b;
        logic [2:0] id;
        logic [5:0] rv;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

`ifdef CP0_IRQ_CNT_EN
    localparam logic [5:0] C_CNT_EXP = 6'd5;
`else
    localparam logic [5:0] C_CNT_EXP = 6'd0;
`endif

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expect status outputs n edges after the current cycle.
    task automatic exp_st(int n, logic [5:0] hw, logic b, logic [2:0] id, string nm);
        exp_t e;
        e.cyc = cyc + n; e.rd = 1'b0; e.hw = hw; e.b = b; e.id = id; e.rv = '0; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic exp_rd(int n, logic [5:0] rv, string nm);
        exp_t e;
        e.cyc = cyc + n; e.rd = 1'b1; e.hw = '0; e.b = 1'b0; e.id = '0; e.rv = rv; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            begin
                int i;
                i = 0;
                while (i < sb.size()) begin
                    if (sb[i].cyc < cyc) begin
                        checks++; failures++;
                        $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].nm, sb[i].cyc);
                        sb.delete(i);
                    end else if (sb[i].cyc == cyc) begin
                        checks++;
                        if (sb[i].rd) begin
                            if (cfg_rdata !== sb[i].rv) begin
                                failures++;
                                $display("FAIL %s: cyc=%0d addr=%0d rdata got %b want %b",
                                         sb[i].nm, cyc, cfg_addr, cfg_rdata, sb[i].rv);
                            end
                        end else if ({hwint, busy, irq_id} !== {sb[i].hw, sb[i].b, sb[i].id}) begin
                            failures++;
                            $display("FAIL %s: cyc=%0d got hwint=%b busy=%b id=%0d want hwint=%b busy=%b id=%0d",
                                     sb[i].nm, cyc, hwint, busy, irq_id, sb[i].hw, sb[i].b, sb[i].id);
                        end
                        sb.delete(i);
                    end else begin
                        i++;
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        reset = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        cp0_take = 1'b0; cp0_eret = 1'b0;
        tick(3);
        reset = 1'b0;
        exp_st(0, 6'b000000, 1'b0, 3'd0, "reset_status");
        exp_rd(0, 6'b111111, "reset_mask");

        // Edge src0 single-cycle pulse
        tick();
        irq_in = 6'b000001; cfg_addr = 2'd1;
        exp_st(1, 6'b000000, 1'b0, 3'd0, "edge0_not_yet");
        exp_rd(1, 6'b000001, "edge0_pending");
        exp_st(2, 6'b000001, 1'b0, 3'd0, "edge0_hwint");
        tick();
        irq_in = '0;
        tick();
        cp0_take = 1'b1;
        exp_st(1, 6'b000000, 1'b1, 3'd0, "edge0_service");
        exp_rd(1, 6'b000000, "edge0_pend_clr");
        tick();
        cp0_take = 1'b0;
        exp_st(1, 6'b000000, 1'b1, 3'd0, "edge0_hold");
        tick();
        cp0_eret = 1'b1;
        exp_st(1, 6'b000000, 1'b0, 3'd0, "edge0_eret");
        tick();
        cp0_eret = 1'b0;
        tick();

        // Level src3 + src5: priority, then src5 after src3 drops
        irq_in = 6'b101000;
        exp_st(2, 6'b001000, 1'b0, 3'd3, "lvl_prio3");
        tick(2);
        cp0_take = 1'b1; irq_in = 6'b100000;
        exp_st(1, 6'b000000, 1'b1, 3'd3, "lvl3_service");
        tick();
        cp0_take = 1'b0; cp0_eret = 1'b1;
        exp_st(1, 6'b000000, 1'b0, 3'd3, "lvl3_eret");
        tick();
        cp0_eret = 1'b0;
        exp_st(1, 6'b100000, 1'b0, 3'd5, "lvl5_req");
        tick();
        irq_in = '0;
        exp_st(1, 6'b100000, 1'b0, 3'd5, "lvl5_hold");
        exp_st(2, 6'b000000, 1'b0, 3'd5, "lvl5_withdraw");
        tick(3);

        // Level src2 withdrawn while in REQ
        irq_in = 6'b000100;
        exp_st(2, 6'b000100, 1'b0, 3'd2, "lvl2_req");
        tick(2);
        irq_in = '0;
        exp_st(1, 6'b000100, 1'b0, 3'd2, "lvl2_hold");
        exp_st(2, 6'b000000, 1'b0, 3'd2, "lvl2_withdraw");
        tick(3);

        // Mask blocks a pending edge; unmask releases it
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 6'b111110; irq_in = 6'b000001;
        tick();
        cfg_we = 1'b0; irq_in = '0; cfg_addr = 2'd1;
        exp_rd(0, 6'b000001, "masked_pending");
        exp_st(1, 6'b000000, 1'b0, 3'd2, "masked_idle1");
        exp_st(2, 6'b000000, 1'b0, 3'd2, "masked_idle2");
        tick(2);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 6'b111111;
        exp_st(1, 6'b000000, 1'b0, 3'd2, "unmask_edge");
        exp_st(2, 6'b000001, 1'b0, 3'd0, "unmask_req");
        tick();
        cfg_we = 1'b0;
        tick();
        // Simultaneous take + eret in REQ goes to SERVICE
        cp0_take = 1'b1; cp0_eret = 1'b1;
        exp_st(1, 6'b000000, 1'b1, 3'd0, "take_eret_service");
        tick();
        cp0_take = 1'b0; cp0_eret = 1'b0;
        tick();
        cp0_eret = 1'b1;
        exp_st(1, 6'b000000, 1'b0, 3'd0, "take_eret_exit");
        tick();
        cp0_eret = 1'b0;
        tick();

        // Write-1-to-clear of a masked edge pending
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 6'b111110; irq_in = 6'b000001;
        tick();
        cfg_addr = 2'd1; cfg_wdata = 6'b000001; irq_in = '0;
        exp_rd(0, 6'b000001, "w1c_before");
        tick();
        cfg_addr = 2'd0; cfg_wdata = 6'b111111;
        tick();
        cfg_we = 1'b0; cfg_addr = 2'd1;
        exp_rd(0, 6'b000000, "w1c_after");
        exp_st(1, 6'b000000, 1'b0, 3'd0, "w1c_noreq1");
        exp_st(2, 6'b000000, 1'b0, 3'd0, "w1c_noreq2");
        tick(3);

        // Edge src0 arriving while level src4 is in service
        irq_in = 6'b010000;
        exp_st(2, 6'b010000, 1'b0, 3'd4, "src4_req");
        tick(2);
        cp0_take = 1'b1; irq_in = '0;
        exp_st(1, 6'b000000, 1'b1, 3'd4, "src4_service");
        tick();
        cp0_take = 1'b0; irq_in = 6'b000001;
        exp_st(1, 6'b000000, 1'b1, 3'd4, "svc_edge_blocked1");
        tick();
        irq_in = '0;
        exp_st(1, 6'b000000, 1'b1, 3'd4, "svc_edge_blocked2");
        tick();
        cp0_eret = 1'b1;
        exp_st(1, 6'b000000, 1'b0, 3'd4, "src4_eret");
        exp_st(2, 6'b000001, 1'b0, 3'd0, "post_eret_req0");
        tick();
        cp0_eret = 1'b0;
        tick();
        cp0_take = 1'b1;
        exp_st(1, 6'b000000, 1'b1, 3'd0, "src0_service");
        tick();
        cp0_take = 1'b0;
        tick();
        cp0_take = 1'b1;
        exp_st(1, 6'b000000, 1'b1, 3'd0, "take_in_service_ignored");
        tick();
        cp0_take = 1'b0; cp0_eret = 1'b1;
        exp_st(1, 6'b000000, 1'b0, 3'd0, "src0_eret");
        tick();
        cp0_eret = 1'b0;

        // Service count, count clear, reserved address
        cfg_addr = 2'd2;
        exp_rd(0, C_CNT_EXP, "count_read");
        tick();
        cfg_we = 1'b1; cfg_wdata = 6'b000000;
        tick();
        cfg_we = 1'b0;
        exp_rd(0, 6'b000000, "count_cleared");
        tick();
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 6'b111111;
        tick();
        cfg_we = 1'b0;
        exp_rd(0, 6'b000000, "reserved_read");
        tick();
        cfg_addr = 2'd0;
        exp_rd(0, 6'b111111, "mask_after_reserved_wr");
        tick();

        // Reset in the middle of service
        irq_in = 6'b100000;
        exp_st(2, 6'b100000, 1'b0, 3'd5, "pre_rst_req");
        tick(2);
        cp0_take = 1'b1;
        exp_st(1, 6'b000000, 1'b1, 3'd5, "pre_rst_service");
        tick();
        cp0_take = 1'b0; irq_in = '0;
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 6'b000111;
        tick();
        cfg_we = 1'b0;
        reset = 1'b1;
        exp_st(0, 6'b000000, 1'b0, 3'd0, "midsvc_reset");
        exp_rd(0, 6'b111111, "midsvc_reset_mask");
        tick();
        reset = 1'b0;
        exp_st(1, 6'b000000, 1'b0, 3'd0, "post_reset_idle");
        tick(4);

        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
